// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled start detect, centre sampling, LSB-first data, optional parity, 1/2 stop bits.
// Latency: o_valid pulses 1 clock after the tick that samples the last stop bit (mid stop bit).
// Backpressure: none; one frame in flight, consumer must take o_data before the next o_valid.
// Optional: define UART_RX_MAJORITY_EN for a 3-sample majority vote per bit.
module uart_rx #(
    parameter int DATA_BITS     = 8,
    parameter int SAMPLING_RATE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tick,
    input  logic                 i_rx,
    input  logic                 i_parity_en,
    input  logic                 i_parity_odd,
    input  logic                 i_stop2,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int CW = $clog2(SAMPLING_RATE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLING_RATE - 1);
`ifdef UART_RX_MAJORITY_EN
    // Vote is decided one tick past the centre so all three samples are in hand.
    localparam logic [CW-1:0] CNT_MID  = CW'(SAMPLING_RATE / 2);
`else
    localparam logic [CW-1:0] CNT_MID  = CW'(SAMPLING_RATE / 2 - 1);
`endif
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_en_q, par_en_d;
    logic                   odd_q, odd_d;
    logic                   stop2_q, stop2_d;
    logic                   par_err_q, par_err_d;
    logic                   stop_err_q, stop_err_d;
    logic                   armed_q, armed_d;
    logic                   done;
    logic                   rx_meta, rx_s;
    logic                   bit_val;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote_h;

    // History of the two previous tick samples; with the current one they form the vote.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vote_h <= 2'b11;
        end else if (i_tick) begin
            vote_h <= {vote_h[0], rx_s};
        end
    end

    assign bit_val = (vote_h[1] & vote_h[0]) | (vote_h[1] & rx_s) | (vote_h[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    // Frame state and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            odd_q      <= 1'b0;
            stop2_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            armed_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            odd_q      <= odd_d;
            stop2_q    <= stop2_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            armed_q    <= armed_d;
        end
    end

    // Next-state logic: tick-driven bit timing, sampling and frame completion.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        odd_d      = odd_q;
        stop2_d    = stop2_q;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        armed_d    = armed_q;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d    = S_START;
                    cnt_d      = '0;
                    par_en_d   = i_parity_en;
                    odd_d      = i_parity_odd;
                    stop2_d    = i_stop2;
                    par_err_d  = 1'b0;
                    stop_err_d = 1'b0;
                end
            end
            S_START: if (i_tick) begin
                if (cnt_q == CNT_MID) begin
                    if (bit_val) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_DATA;
                        cnt_d    = '0;
                        bitcnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: if (i_tick) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    shift_d  = {bit_val, shift_q[DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == BIT_LAST) begin
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: if (i_tick) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_err_d = (^shift_q) ^ bit_val ^ odd_q;
                    state_d   = S_STOP1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP1: if (i_tick) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    stop_err_d = ~bit_val;
                    if (stop2_q) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d = S_IDLE;
                        done    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP2: if (i_tick) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    stop_err_d = stop_err_q | ~bit_val;
                    state_d    = S_IDLE;
                    done       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A bad stop bit disarms so a held break cannot retrigger until the line goes high.
        if (done && stop_err_d) begin
            armed_d = 1'b0;
        end
    end

    // Output word and flags update together with the one-cycle valid pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_valid <= done;
            if (done) begin
                o_data       <= shift_q;
                o_parity_err <= par_err_q;
                o_frame_err  <= stop_err_d;
            end
        end
    end

    assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Directed + randomized bench for uart_rx with a frame-level reference model.
module tb_uart_rx;
    localparam int DB = 8;
    localparam int SR = 16;

    logic          i_clk        = 1'b0;
    logic          i_rst_n      = 1'b1;
    logic          i_tick       = 1'b0;
    logic          i_rx         = 1'b1;
    logic          i_parity_en  = 1'b0;
    logic          i_parity_odd = 1'b0;
    logic          i_stop2      = 1'b0;
    logic [DB-1:0] o_data;
    logic          o_valid;
    logic          o_parity_err;
    logic          o_frame_err;
    logic          o_busy;

    int            tests  = 0;
    int            fails  = 0;
    int            vcount = 0;
    logic [DB-1:0] cap_data = '0;
    logic          cap_pe   = 1'b0;
    logic          cap_fe   = 1'b0;

    uart_rx #(.DATA_BITS(DB), .SAMPLING_RATE(SR)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_tick       (i_tick),
        .i_rx         (i_rx),
        .i_parity_en  (i_parity_en),
        .i_parity_odd (i_parity_odd),
        .i_stop2      (i_stop2),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Tick every 4 clocks, changed on the falling edge.
    initial begin
        forever begin
            repeat (3) @(negedge i_clk);
            i_tick = 1'b1;
            @(negedge i_clk);
            i_tick = 1'b0;
        end
    end

    // Capture every cycle o_valid is high.
    always @(negedge i_clk) begin
        if (o_valid) begin
            vcount   = vcount + 1;
            cap_data = o_data;
            cap_pe   = o_parity_err;
            cap_fe   = o_frame_err;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge i_clk);
            if (i_tick) k++;
        end
        #1;
    endtask

    task automatic drive_bit(input logic v, input bit glitch);
        i_rx = v;
        if (glitch) begin
            wait_ticks(SR/2 - 1);
            i_rx = ~v;
            wait_ticks(1);
            i_rx = v;
            wait_ticks(SR/2);
        end else begin
            wait_ticks(SR);
        end
    endtask

    task automatic idle(input int nbits);
        i_rx = 1'b1;
        wait_ticks(SR * nbits);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd, input bit pbit,
                              input bit st2, input bit s1, input bit s2,
                              input bit glitch, input bit scramble);
        i_parity_en  = pen;
        i_parity_odd = podd;
        i_stop2      = st2;
        wait_ticks(1);
        drive_bit(1'b0, glitch);
        if (scramble) begin
            i_parity_en  = 1'($urandom_range(0, 1));
            i_parity_odd = 1'($urandom_range(0, 1));
            i_stop2      = 1'($urandom_range(0, 1));
        end
        for (int j = 0; j < DB; j++) drive_bit(d[j], glitch);
        if (pen) drive_bit(pbit, glitch);
        drive_bit(s1, glitch);
        if (st2) drive_bit(s2, glitch);
    endtask

    // Frame-level model: parity error when the count of ones (data + parity bit) has the wrong sense.
    function automatic bit model_perr(input logic [7:0] d, input bit pen, input bit podd, input bit pbit);
        if (!pen) return 1'b0;
        return ((($countones(d) + int'(pbit) + int'(podd)) % 2) == 1);
    endfunction

    function automatic bit model_ferr(input bit st2, input bit s1, input bit s2);
        return (!s1) || (st2 && !s2);
    endfunction

    task automatic expect_frame(input string tag, input int base, input logic [7:0] d,
                                input bit pe, input bit fe);
        check({tag, "_count"}, 32'(vcount - base), 32'd1);
        check({tag, "_data"},  32'(cap_data), 32'(d));
        check({tag, "_perr"},  32'(cap_pe), 32'(pe));
        check({tag, "_ferr"},  32'(cap_fe), 32'(fe));
        check({tag, "_busy"},  32'(o_busy), 32'd0);
    endtask

    initial begin
        int            base;
        logic [7:0]    d;
        bit            pen, podd, pbit, st2, s1, s2;

        #2 i_rst_n = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        check("rst_data",  32'(o_data), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_perr",  32'(o_parity_err), 32'd0);
        check("rst_ferr",  32'(o_frame_err), 32'd0);
        check("rst_busy",  32'(o_busy), 32'd0);
        i_rst_n = 1'b1;
        idle(2);

        base = vcount;
        send_frame(8'hA5, 0, 0, 0, 0, 1, 1, 0, 0);
        expect_frame("basic_a5", base, 8'hA5, 0, 0);
        idle(1);

        base = vcount;
        send_frame(8'h3C, 1, 0, 0, 0, 1, 1, 0, 0);
        expect_frame("even_ok", base, 8'h3C, model_perr(8'h3C, 1, 0, 0), 0);
        idle(1);
        base = vcount;
        send_frame(8'h3C, 1, 0, 1, 0, 1, 1, 0, 0);
        expect_frame("even_bad", base, 8'h3C, 1, 0);
        idle(1);
        base = vcount;
        send_frame(8'h01, 1, 1, 0, 0, 1, 1, 0, 0);
        expect_frame("odd_ok", base, 8'h01, 0, 0);
        idle(1);

        base = vcount;
        send_frame(8'h55, 0, 0, 0, 1, 1, 0, 0, 0);
        expect_frame("stop2_low", base, 8'h55, 0, 1);
        base = vcount;
        wait_ticks(3 * SR);
        check("break_no_valid", 32'(vcount - base), 32'd0);
        check("break_busy", 32'(o_busy), 32'd0);
        idle(1);
        base = vcount;
        send_frame(8'h55, 0, 0, 0, 1, 1, 1, 0, 0);
        expect_frame("after_break", base, 8'h55, 0, 0);
        idle(1);

        base = vcount;
        i_rx = 1'b0;
        wait_ticks(5);
        i_rx = 1'b1;
        check("glitch_busy_hi", 32'(o_busy), 32'd1);
        wait_ticks(5);
        check("glitch_busy_lo", 32'(o_busy), 32'd0);
        check("glitch_no_valid", 32'(vcount - base), 32'd0);
        idle(1);
        base = vcount;
        send_frame(8'h81, 0, 0, 0, 0, 1, 1, 0, 0);
        expect_frame("post_glitch", base, 8'h81, 0, 0);
        idle(1);

        base = vcount;
        i_parity_en = 1'b0;
        i_stop2     = 1'b0;
        drive_bit(1'b0, 0);
        for (int j = 0; j < 4; j++) drive_bit(1'b1, 0);
        wait_ticks(SR/2);
        i_rst_n = 1'b0;
        #1;
        check("midrst_data",  32'(o_data), 32'd0);
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_busy",  32'(o_busy), 32'd0);
        check("midrst_flags", 32'({o_parity_err, o_frame_err}), 32'd0);
        wait_ticks(SR);
        i_rst_n = 1'b1;
        idle(2);
        check("midrst_no_valid", 32'(vcount - base), 32'd0);
        base = vcount;
        send_frame(8'h12, 0, 0, 0, 0, 1, 1, 0, 0);
        expect_frame("post_rst", base, 8'h12, 0, 0);
        idle(1);

        for (int n = 0; n < 16; n++) begin
            d    = 8'($urandom_range(0, 255));
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            pbit = 1'($urandom_range(0, 1));
            st2  = 1'($urandom_range(0, 1));
            s1   = ($urandom_range(0, 5) != 0);
            s2   = ($urandom_range(0, 5) != 0);
            base = vcount;
            send_frame(d, pen, podd, pbit, st2, s1, s2, 0, 1);
            expect_frame($sformatf("rand%0d", n), base, d,
                         model_perr(d, pen, podd, pbit), model_ferr(st2, s1, s2));
            idle(1);
        end

`ifdef UART_RX_MAJORITY_EN
        base = vcount;
        send_frame(8'h0F, 0, 0, 0, 0, 1, 1, 1, 0);
        expect_frame("majority", base, 8'h0F, 0, 0);
        idle(1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
